rgb2y_stream: RTL



---
 rtl/rgb2y_stream_if.sv | 30 +++
 rtl/rgb2y_stream.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rgb2y_stream_if.sv
// Valid/ready stream bundle for rgb2y_stream: an RGB888 input stream and an 8-bit luma output stream.
// The design takes the slave view; the pixel source / luma sink takes the master view.
interface rgb2y_stream_if #(
    parameter int IN_DATA_WIDTH = 24
);
    logic [IN_DATA_WIDTH-1:0] in_rgb_data;
    logic                     in_rgb_valid;
    logic                     in_rgb_ready;
    logic [7:0]               out_y_data;
    logic                     out_y_valid;
    logic                     out_y_ready;

    modport master (
        output in_rgb_data,
        output in_rgb_valid,
        input  in_rgb_ready,
        input  out_y_data,
        input  out_y_valid,
        output out_y_ready
    );

    modport slave (
        input  in_rgb_data,
        input  in_rgb_valid,
        output in_rgb_ready,
        output out_y_data,
        output out_y_valid,
        input  out_y_ready
    );
endinterface

// File: rtl/rgb2y_stream.sv
// RGB888 -> 8-bit luma converter: 3-stage stall-all pipeline with raster counters and frame_done pulse.
// Optional macro Y_BT601_LIMITED_EN selects limited-range BT.601 luma (16..235) instead of full range.
module rgb2y_stream #(
    parameter int IMAGE_WIDTH   = 1920,
    parameter int IMAGE_HEIGHT  = 1080,
    parameter int IN_DATA_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rgb2y_stream_if.slave        stream,
    output logic                 frame_done,
    output logic [15:0]          col_cnt,
    output logic [15:0]          row_cnt
);

`ifdef Y_BT601_LIMITED_EN
    localparam logic [15:0] C_R      = 16'd66;
    localparam logic [15:0] C_G      = 16'd129;
    localparam logic [15:0] C_B      = 16'd25;
    localparam logic [7:0]  Y_OFFSET = 8'd16;
`else
    localparam logic [15:0] C_R      = 16'd77;
    localparam logic [15:0] C_G      = 16'd150;
    localparam logic [15:0] C_B      = 16'd29;
    localparam logic [7:0]  Y_OFFSET = 8'd0;
`endif

    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

    logic        w_en;
    logic        w_accept;
    logic        w_colLast;
    logic        w_rowLast;
    logic        w_isLast;
    logic [15:0] w_r;
    logic [15:0] w_g;
    logic [15:0] w_b;
    logic [15:0] w_sum;

    logic [15:0] r_col;
    logic [15:0] r_row;

    logic        r_v1;
    logic        r_last1;
    logic [15:0] r_pr;
    logic [15:0] r_pg;
    logic [15:0] r_pb;

    logic        r_v2;
    logic        r_last2;
    logic [15:0] r_sum;

    logic        r_yValid;
    logic        r_last3;
    logic [7:0]  r_yData;

    logic        r_frameDone;

    // One enable for the whole pipeline: it only moves when the output slot is free or draining.
    assign w_en     = !r_yValid || stream.out_y_ready;
    assign w_accept = stream.in_rgb_valid && w_en;

    assign w_r = {8'd0, stream.in_rgb_data[IN_DATA_WIDTH-1  -: 8]};
    assign w_g = {8'd0, stream.in_rgb_data[IN_DATA_WIDTH-9  -: 8]};
    assign w_b = {8'd0, stream.in_rgb_data[IN_DATA_WIDTH-17 -: 8]};

    assign w_colLast = (r_col == LAST_COL);
    assign w_rowLast = (r_row == LAST_ROW);
    assign w_isLast  = w_colLast && w_rowLast;

    // Peak is 255*256 + 128 = 65408, so the 16-bit sum never wraps.
    assign w_sum = r_pr + r_pg + r_pb + 16'd128;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= 16'd0;
            r_row <= 16'd0;
        end else if (w_accept) begin
            if (w_colLast) begin
                r_col <= 16'd0;
                r_row <= w_rowLast ? 16'd0 : r_row + 16'd1;
            end else begin
                r_col <= r_col + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_last1  <= 1'b0;
            r_pr     <= 16'd0;
            r_pg     <= 16'd0;
            r_pb     <= 16'd0;
            r_v2     <= 1'b0;
            r_last2  <= 1'b0;
            r_sum    <= 16'd0;
            r_yValid <= 1'b0;
            r_last3  <= 1'b0;
            r_yData  <= 8'd0;
        end else if (w_en) begin
            r_v1    <= w_accept;
            r_last1 <= w_accept && w_isLast;
            if (w_accept) begin
                r_pr <= w_r * C_R;
                r_pg <= w_g * C_G;
                r_pb <= w_b * C_B;
            end

            r_v2    <= r_v1;
            r_last2 <= r_last1;
            if (r_v1) begin
                r_sum <= w_sum;
            end

            r_yValid <= r_v2;
            r_last3  <= r_last2;
            if (r_v2) begin
                r_yData <= r_sum[15:8] + Y_OFFSET;
            end
        end
    end

    // Pulse follows the output handshake of the frame's final pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= r_yValid && stream.out_y_ready && r_last3;
        end
    end

    assign stream.in_rgb_ready = w_en;
    assign stream.out_y_data   = r_yData;
    assign stream.out_y_valid  = r_yValid;
    assign frame_done          = r_frameDone;
    assign col_cnt             = r_col;
    assign row_cnt             = r_row;

endmodule
